rotary_operand_alu: RTL



---
 rtl/rotary_operand_alu.sv | 119 +++++++++++
 1 files changed

// File: rtl/rotary_operand_alu.sv
// rtl/rotary_operand_alu.sv - quadrature-encoder stepped operand entry with add/subtract result
// Each CW detent commits one entry step (clear, A/B slice loads MSB first, mode); CCW steps back.
module rotary_operand_alu #(
  parameter  int WIDTH  = 7,
  parameter  int SLICE  = 4,
  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE,
  localparam int DONE   = 2 * NSLICE + 2,
  localparam int SW     = $clog2(DONE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ROT_A,
  input  logic             ROT_B,
  input  logic [SLICE-1:0] holder,
  input  logic             sub,
  output logic [WIDTH:0]   led,
  output logic [SW-1:0]    step,
  output logic             valid
);

  localparam int MODE = 2 * NSLICE + 1;

  logic             a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic             evt_q, evt_prev_q, dir_q, pulse_q;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             cin_q, cin_d, op_q, op_d;
  logic [WIDTH:0]   led_q, led_d;
  logic [WIDTH:0]   a_ext, b_ext, c_ext;

  // Front end: evt/prev-evt reset high so a detent must pass through 00 before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q     <= 1'b1;
      a_s2_q     <= 1'b1;
      b_s1_q     <= 1'b1;
      b_s2_q     <= 1'b1;
      evt_q      <= 1'b1;
      evt_prev_q <= 1'b1;
      dir_q      <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      a_s1_q     <= ROT_A;
      a_s2_q     <= a_s1_q;
      b_s1_q     <= ROT_B;
      b_s2_q     <= b_s1_q;
      case ({a_s2_q, b_s2_q})
        2'b00:   evt_q <= 1'b0;
        2'b11:   evt_q <= 1'b1;
        2'b01:   dir_q <= 1'b1;
        default: dir_q <= 1'b0;
      endcase
      evt_prev_q <= evt_q;
      pulse_q    <= evt_q & ~evt_prev_q;
    end
  end

  always_comb begin
    step_d = step_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cin_d  = cin_q;
    op_d   = op_q;
    led_d  = led_q;
    a_ext  = {1'b0, opa_q};
    b_ext  = {1'b0, opb_q};
    c_ext  = {{WIDTH{1'b0}}, holder[0]};
    if (pulse_q) begin
      if (dir_q) begin
        step_d = (step_q == SW'(DONE)) ? '0 : step_q + 1'b1;
        if (step_q == '0) begin
          opa_d = '0;
          opb_d = '0;
          cin_d = 1'b0;
          op_d  = 1'b0;
          led_d = '0;
        end else if (step_q == SW'(MODE)) begin
          cin_d = holder[0];
          op_d  = sub;
          led_d = sub ? (a_ext - b_ext - c_ext) : (a_ext + b_ext + c_ext);
        end
        // Slice s of an operand is loaded on step NSLICE-s (A) or 2*NSLICE-s (B); pad bits drop.
        for (int s = 0; s < NSLICE; s++) begin
          for (int b = 0; b < SLICE; b++) begin
            if (s * SLICE + b < WIDTH) begin
              if (step_q == SW'(NSLICE - s)) opa_d[s*SLICE+b] = holder[b];
              if (step_q == SW'(2 * NSLICE - s)) opb_d[s*SLICE+b] = holder[b];
            end
          end
        end
      end else begin
        step_d = (step_q == '0) ? '0 : step_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      op_q   <= 1'b0;
      led_q  <= '0;
    end else begin
      step_q <= step_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cin_q  <= cin_d;
      op_q   <= op_d;
      led_q  <= led_d;
    end
  end

  assign led   = led_q;
  assign step  = step_q;
  assign valid = (step_q == SW'(DONE));

endmodule
